bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single CPU bus between up to MASTER_CH requesters: the IF stage, the MEM stage, and optional DMA/debug masters. It issues registered one-hot grants and holds ownership while the owner keeps its request asserted. Per-master wait outputs feed the pipeline busy inputs of the control unit: IF wait drives IFBusy and MEM wait drives MemBusy.

---
 rtl/bus_arbiter_if.sv | 40 ++++
 rtl/bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbitration interface shared by the requesting masters and the arbiter.
//
// Signals:
//   req       per-master bus request (driven by the masters)
//   grant     registered one-hot grant, all-zero when idle
//   owner     binary index of the current (or last) owner
//   bus_busy  high while any grant bit is set
//   wait_     per-master stall, req & ~grant (feeds IFBusy / MemBusy)
//   timeout   one-cycle pulse on forced preemption
//
// Modports: master (requester side), slave (arbiter side).
interface bus_arbiter_if #(
    parameter int unsigned MASTER_CH = 4,
    parameter int unsigned OWNER_W   = 2
) ();
    logic [MASTER_CH-1:0] req;
    logic [MASTER_CH-1:0] grant;
    logic [OWNER_W-1:0]   owner;
    logic                 bus_busy;
    logic [MASTER_CH-1:0] wait_;
    logic                 timeout;

    modport master (
        output req,
        input  grant,
        input  owner,
        input  bus_busy,
        input  wait_,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output owner,
        output bus_busy,
        output wait_,
        output timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared CPU bus (IF stage, MEM stage, optional DMA/debug).
// Issues a registered one-hot grant and keeps it while the owner holds its request.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high reset
//   bus    bus_arbiter_if.slave: req in; grant, owner, bus_busy, wait_, timeout out
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to preempt an owner that has held the bus
// for MAX_HOLD cycles while others wait. Without it, ownership is unlimited and
// timeout is tied low.
module bus_arbiter #(
    parameter int unsigned MASTER_CH = 4,
    parameter int unsigned OWNER_W   = 2,
    parameter int unsigned MAX_HOLD  = 16
) (
    input logic          clk,
    input logic          reset,
    bus_arbiter_if.slave bus
);

    if (MASTER_CH < 2 || MASTER_CH > 8 || (2 ** OWNER_W) < MASTER_CH || MAX_HOLD < 2)
    begin : g_param_check
        $error("bus_arbiter: illegal parameter combination");
    end

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e               state_q, state_d;
    logic [MASTER_CH-1:0] grant_q, grant_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   last_q, last_d;

    logic [MASTER_CH-1:0] cand;
    logic                 owner_req;
    logic                 preempt;

    logic                 hi_found, lo_found, pick_found;
    logic [OWNER_W-1:0]   hi_idx, lo_idx, pick_idx;
    logic [MASTER_CH-1:0] hi_oh, lo_oh, pick_oh;

    // Owner's request bit is masked out, so the same scan serves IDLE arbitration,
    // release hand-off and preemption.
    assign owner_req = |(bus.req & grant_q);
    assign cand      = bus.req & ~grant_q;

    // Round-robin scan starting after last_q: first set bit above last_q wins,
    // otherwise the first set bit at or below it (wrap-around).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_oh    = '0;
        lo_oh    = '0;
        for (int j = 0; j < int'(MASTER_CH); j++) begin
            if (cand[j]) begin
                if (j > int'(last_q)) begin
                    if (!hi_found) begin
                        hi_found  = 1'b1;
                        hi_idx    = OWNER_W'(j);
                        hi_oh[j]  = 1'b1;
                    end
                end else if (!lo_found) begin
                    lo_found  = 1'b1;
                    lo_idx    = OWNER_W'(j);
                    lo_oh[j]  = 1'b1;
                end
            end
        end
        pick_found = hi_found | lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
        pick_oh    = hi_found ? hi_oh : lo_oh;
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    assign preempt = (state_q == StOwned) && owner_req && (|cand) &&
                     (hold_q == HoldW'(MAX_HOLD - 1));

    always_comb begin
        hold_d    = hold_q;
        timeout_d = preempt;
        if (state_q != StOwned || grant_d != grant_q) begin
            hold_d = '0;
        end else if (owner_req && (|cand)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign preempt     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = StOwned;
                end
            end
            StOwned: begin
                // Release and preemption both hand off directly, no idle bubble.
                if (!owner_req || preempt) begin
                    if (pick_found) begin
                        grant_d = pick_oh;
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                    end else begin
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= OWNER_W'(MASTER_CH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = |grant_q;
    assign bus.wait_    = bus.req & ~grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (MASTER_CH=4, OWNER_W=2, MAX_HOLD=16).
// Stimulus drives one vector per cycle and queues the outputs expected in that cycle;
// the monitor pops and compares on the falling edge.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    bus_arbiter_if #(.MASTER_CH(4), .OWNER_W(2)) bus ();

    bus_arbiter #(
        .MASTER_CH (4),
        .OWNER_W   (2),
        .MAX_HOLD  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] grant;
        logic [1:0] owner;
        logic       busy;
        logic [3:0] wt;
        logic       to;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant",    32'(bus.grant),    32'(e.grant));
            chk("owner",    32'(bus.owner),    32'(e.owner));
            chk("bus_busy", 32'(bus.bus_busy), 32'(e.busy));
            chk("wait_",    32'(bus.wait_),    32'(e.wt));
            chk("timeout",  32'(bus.timeout),  32'(e.to));
            chk("onehot0",  32'($onehot0(bus.grant)), 32'd1);
        end
    end

    // Drive one cycle and queue the outputs expected during it.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                        input logic [1:0] eo, input logic eb, input logic et);
        exp_t e;
        reset    = r;
        bus.req  = rq;
        e.grant  = eg;
        e.owner  = eo;
        e.busy   = eb;
        e.wt     = rq & ~eg;
        e.to     = et;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        bus.req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, then first grant: scan starts at master 0.
        step(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        step(0, 4'b0110, 4'b0000, 2'd0, 0, 0);
        step(0, 4'b0110, 4'b0010, 2'd1, 1, 0);
        // Owner 1 drops: direct hand-off to 2.
        step(0, 4'b0101, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b0101, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0000, 4'b0100, 2'd2, 1, 0);
        // Idle keeps last owner; master 3 then releases to idle.
        step(0, 4'b1000, 4'b0000, 2'd2, 0, 0);
        step(0, 4'b1000, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b0000, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b1001, 4'b0000, 2'd3, 0, 0);
        // All four request, each releases after two grant cycles: 0,1,2,3,0.
        step(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        step(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        step(0, 4'b1110, 4'b0001, 2'd0, 1, 0);
        step(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b1101, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b1011, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b1111, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b1111, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b0111, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b0111, 4'b0001, 2'd0, 1, 0);
        // Reset mid-ownership of master 2; afterwards scan restarts at 0.
        step(0, 4'b0100, 4'b0001, 2'd0, 1, 0);
        step(1, 4'b0100, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b1010, 4'b0000, 2'd0, 0, 0);
        step(0, 4'b1010, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b0000, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b0000, 4'b0000, 2'd1, 0, 0);
        // Master 0 holds while master 2 waits.
        step(0, 4'b0001, 4'b0000, 2'd1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 4'b0101, 4'b0001, 2'd0, 1, 0);
`ifdef BUS_ARB_TIMEOUT_EN
        step(0, 4'b0101, 4'b0100, 2'd2, 1, 1);
        step(0, 4'b0101, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0000, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0000, 4'b0000, 2'd2, 0, 0);
`else
        for (int i = 0; i < 84; i++) step(0, 4'b0101, 4'b0001, 2'd0, 1, 0);
        step(0, 4'b0000, 4'b0001, 2'd0, 1, 0);
        step(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
`endif
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
